// File: rtl/life_stream_stepper.sv
// One Conway generation over a WIDTH x HEIGHT board streamed in raster order.
// Optional macro LIFE_TORUS_EN wraps the board edges toroidally.

module full_adder_3_bit_to_4_bit (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [3:0] sum
);
    assign sum = {1'b0, a} + {1'b0, b};
endmodule

module life_stream_stepper #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic       IN_CELL,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic       OUT_CELL,
    output logic       OUT_LAST,
    output logic [7:0] GEN_COUNT
);
    localparam int N  = WIDTH * HEIGHT;
    localparam int IW = $clog2(N);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {LOAD, EMIT} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    board_q, board_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [7:0]      gen_q, gen_d;

    logic [IW-1:0]   cur_idx;
    logic            last;
    logic [RW-1:0]   r_up, r_dn;
    logic [CW-1:0]   c_lf, c_rt;
    logic            up_ok, dn_ok, lf_ok, rt_ok;
    logic            nw, n, ne, w, e, sw, s, se, self_cell;
    logic [2:0]      top, bot, mid;
    logic [3:0]      sum_tb, count;
    logic            sum_tb_msb_unused;
    logic            alive;
    logic            adv;

    assign cur_idx = IW'(int'(row_q) * WIDTH + int'(col_q));
    assign last    = (row_q == RW'(HEIGHT - 1)) && (col_q == CW'(WIDTH - 1));

    // Off-board neighbours are masked by the *_ok flags, never indexed.
    function automatic logic cell_at(input logic ok, input logic [RW-1:0] r,
                                     input logic [CW-1:0] c);
        logic [IW-1:0] i;
        i = IW'(int'(r) * WIDTH + int'(c));
        if (!ok) return 1'b0;
        return board_q[i];
    endfunction

    always_comb begin
`ifdef LIFE_TORUS_EN
        up_ok = 1'b1;
        dn_ok = 1'b1;
        lf_ok = 1'b1;
        rt_ok = 1'b1;
        r_up  = (row_q == '0) ? RW'(HEIGHT - 1) : row_q - RW'(1);
        r_dn  = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
        c_lf  = (col_q == '0) ? CW'(WIDTH - 1) : col_q - CW'(1);
        c_rt  = (col_q == CW'(WIDTH - 1)) ? '0 : col_q + CW'(1);
`else
        up_ok = (row_q != '0);
        dn_ok = (row_q != RW'(HEIGHT - 1));
        lf_ok = (col_q != '0);
        rt_ok = (col_q != CW'(WIDTH - 1));
        r_up  = row_q - RW'(1);
        r_dn  = row_q + RW'(1);
        c_lf  = col_q - CW'(1);
        c_rt  = col_q + CW'(1);
`endif
    end

    always_comb begin
        nw        = cell_at(up_ok & lf_ok, r_up,  c_lf);
        n         = cell_at(up_ok,         r_up,  col_q);
        ne        = cell_at(up_ok & rt_ok, r_up,  c_rt);
        w         = cell_at(lf_ok,         row_q, c_lf);
        e         = cell_at(rt_ok,         row_q, c_rt);
        sw        = cell_at(dn_ok & lf_ok, r_dn,  c_lf);
        s         = cell_at(dn_ok,         r_dn,  col_q);
        se        = cell_at(dn_ok & rt_ok, r_dn,  c_rt);
        self_cell = board_q[cur_idx];
        top       = {2'b0, nw} + {2'b0, n} + {2'b0, ne};
        bot       = {2'b0, sw} + {2'b0, s} + {2'b0, se};
        mid       = {2'b0, w} + {2'b0, e};
    end

    full_adder_3_bit_to_4_bit u_add_tb (.a(top), .b(bot), .sum(sum_tb));
    // top+bot is at most 6, so the low three bits carry the whole value.
    full_adder_3_bit_to_4_bit u_add_all (.a(sum_tb[2:0]), .b(mid), .sum(count));
    assign sum_tb_msb_unused = sum_tb[3];

    assign alive     = (count == 4'd3) || (self_cell && (count == 4'd2));
    assign GEN_COUNT = gen_q;

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        row_d     = row_q;
        col_d     = col_q;
        gen_d     = gen_q;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        OUT_CELL  = 1'b0;
        OUT_LAST  = 1'b0;
        adv       = 1'b0;
        case (state_q)
            LOAD: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    board_d[cur_idx] = IN_CELL;
                    adv              = 1'b1;
                    if (last) state_d = EMIT;
                end
            end
            EMIT: begin
                OUT_VALID = 1'b1;
                OUT_CELL  = alive;
                OUT_LAST  = last;
                if (OUT_READY) begin
                    adv = 1'b1;
                    if (last) begin
                        gen_d   = gen_q + 8'd1;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
        if (adv) begin
            if (last) begin
                row_d = '0;
                col_d = '0;
            end else if (col_q == CW'(WIDTH - 1)) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= LOAD;
            board_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            gen_q   <= '0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            row_q   <= row_d;
            col_q   <= col_d;
            gen_q   <= gen_d;
        end
    end
endmodule

// File: doc/life_stream_stepper.md
# life_stream_stepper

Computes one Conway generation over a fixed WIDTH×HEIGHT board delivered as a raster-order bit stream and emits the next generation as a raster-order bit stream. Sits directly downstream of the neighbour-count adders: it buffers the board, forms each cell's 0–8 neighbour count with two `full_adder_3_bit_to_4_bit` instances, and applies the life rule. It is the per-generation engine between the board source (loader or previous stepper) and the board sink (display or next stepper).

## Interface
- `WIDTH`, 8: board columns; range 3–32.
- `HEIGHT`, 8: board rows; range 3–32.
- `CLK`  in  1  rising-edge clock.
- `RST_N`  in  1  reset, asynchronous assert, active-low.
- `IN_VALID`  in  1  `IN_CELL` carries a valid cell.
- `IN_READY`  out  1  block accepts an input cell this cycle.
- `IN_CELL`  in  1  cell state (1 = alive), raster order: row 0 col 0 first, column fastest.
- `OUT_VALID`  out  1  `OUT_CELL` carries a valid next-generation cell.
- `OUT_READY`  in  1  sink accepts the output cell.
- `OUT_CELL`  out  1  next-generation state, same raster order.
- `OUT_LAST`  out  1  high with the final cell, index WIDTH*HEIGHT-1.
- `GEN_COUNT`  out  8  number of completed generations.

## Operation
- Storage: WIDTH*HEIGHT-bit board register, plus index counter `idx` of width clog2(WIDTH*HEIGHT), held as row/col sub-counters.
- FSM states: LOAD (reset state) and EMIT.
- LOAD:
  - `IN_READY`=1 and `OUT_VALID`=0.
  - On `IN_VALID && IN_READY`, write `IN_CELL` to board[idx] and increment idx.
  - On acceptance at idx = WIDTH*HEIGHT-1, clear idx and enter EMIT.
- EMIT:
  - `IN_READY`=0 and `OUT_VALID`=1.
  - `OUT_CELL` = rule(board[idx], count(idx)).
  - On `OUT_VALID && OUT_READY`, increment idx.
  - On the handshake at the last index: clear idx, increment `GEN_COUNT` (wraps 255→0), return to LOAD.
- Neighbour count:
  - top = sum of the 3 cells in the row above (0–3); bot = sum of the 3 cells in the row below (0–3); mid = left + right (0–2).
  - Adder 1: top + bot (4-bit, 0–6). Adder 2: that result + mid (4-bit, 0–8), zero-extended as needed.
  - The cell itself is excluded from the count.
- Rule: alive next iff count = 3, or (board[idx] = 1 and count = 2).
- Edges: off-board neighbours read as dead (0), unless `LIFE_TORUS_EN` is defined (see Configuration).
- The board is only written in LOAD, so the computation always reads a frozen generation.

## Timing
- Reset (`RST_N` low, asynchronous): state LOAD, idx 0, board all 0, `GEN_COUNT` 0, `IN_READY` 1, `OUT_VALID` 0, `OUT_CELL` 0, `OUT_LAST` 0.
- Reset asserted mid-LOAD or mid-EMIT discards the partial frame. Normal operation starts on the first `CLK` edge after release.
- `OUT_CELL`/`OUT_LAST` are combinational from registered state only (board, idx, FSM); there is no combinational path from inputs to outputs.
- Latency: the first `OUT_VALID` is seen in the cycle after the last input handshake.
- Throughput: one cell per cycle in each phase. A frame takes at least 2*WIDTH*HEIGHT cycles.
- Backpressure: while `OUT_VALID && !OUT_READY`, `OUT_CELL`, `OUT_LAST` and idx hold.
- `IN_VALID` gaps in LOAD stall idx.
- `IN_VALID` during EMIT is ignored; no input is consumed.
- `OUT_READY` during LOAD is ignored.
- `OUT_LAST` = 1 only in EMIT at idx = WIDTH*HEIGHT-1.

## Configuration
- `LIFE_TORUS_EN` defined: the board wraps toroidally.
  - Row -1 maps to HEIGHT-1; row HEIGHT maps to 0.
  - Column -1 maps to WIDTH-1; column WIDTH maps to 0.
- Undefined: off-board neighbours are dead. No wrap logic is compiled.

## Test plan
- Blinker, 5×5, no torus:
  - Load vertical row1–3 col2.
  - Output is horizontal row2 col1–3; all else 0.
  - `OUT_LAST` high only on the 25th output; `GEN_COUNT` 0→1.
- Block still life, 4×4:
  - Load cells (1,1),(1,2),(2,1),(2,2).
  - Output is identical. A lone cell at (0,0) on an empty board yields all-zero output.
- Backpressure:
  - During EMIT, hold `OUT_READY`=0 for 5 cycles at idx 7.
  - `OUT_CELL` stable and idx unchanged; the stream resumes with no cell dropped or duplicated.
- Input gaps:
  - Toggle `IN_VALID` every other cycle during LOAD.
  - Output identical to the gap-free run; the first `OUT_VALID` comes exactly 1 cycle after the final input handshake.
- Reset mid-operation:
  - Assert `RST_N`=0 at idx 10 of EMIT.
  - Immediately: `OUT_VALID`=0, `IN_READY`=1, `GEN_COUNT`=0.
  - A following full load behaves as from power-up.
- `LIFE_TORUS_EN`, 5×5:
  - Load horizontal blinker row0 col1–3.
  - Output is col2 at rows 4, 0, 1.
  - Without the macro, output is col2 at rows 0–1 only.
